// File: rtl/gtp_drp_arbiter.sv
// Round-robin arbiter sharing one GTPE2 DRP port among NUM_REQ requesters.
// Define GTP_DRP_TIMEOUT_EN to abort stalled accesses after TIMEOUT_CYCLES WAIT cycles.
module gtp_drp_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      SYSCLK_I,
    input  logic                      RST_I,
    input  logic [NUM_REQ-1:0]        REQ_I,
    input  logic [NUM_REQ-1:0]        REQ_WE_I,
    input  logic [ADDR_W*NUM_REQ-1:0] REQ_ADDR_I,
    input  logic [16*NUM_REQ-1:0]     REQ_DI_I,
    output logic [NUM_REQ-1:0]        ACK_O,
    output logic [15:0]               RDATA_O,
    output logic                      ERR_O,
    output logic [NUM_REQ-1:0]        GNT_O,
    output logic                      BUSY_O,
    output logic                      DRPEN_O,
    output logic                      DRPWE_O,
    output logic [ADDR_W-1:0]         DRPADDR_O,
    output logic [15:0]               DRPDI_O,
    input  logic [15:0]               DRPDO_I,
    input  logic                      DRPRDY_I
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("gtp_drp_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               we_q, we_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               busy_q, busy_d;
    logic               drpen_q, drpen_d;
    logic               drpwe_q, drpwe_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        di_q, di_d;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    int unsigned        cand;
    logic               timeout;

    // Search starts one past the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_vld && REQ_I[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

`ifdef GTP_DRP_TIMEOUT_EN
    localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              err_q, err_d;

    assign timeout = (state_q == S_WAIT) && (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == S_ACCESS) begin
            tcnt_d = '0;
        end else if (state_q == S_WAIT) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge SYSCLK_I) begin
        if (RST_I) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign ERR_O = err_q;
`else
    assign timeout = 1'b0;
    assign ERR_O   = 1'b0;
`endif

    always_ff @(posedge SYSCLK_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (win_vld) state_d = S_ACCESS;
            S_ACCESS: state_d = S_WAIT;
            S_WAIT:   if (DRPRDY_I || timeout) state_d = S_ACK;
            S_ACK:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        ptr_d   = ptr_q;
        we_d    = we_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        drpen_d = 1'b0;
        drpwe_d = 1'b0;
        addr_d  = addr_q;
        di_d    = di_q;
        busy_d  = (state_d != S_IDLE);
`ifdef GTP_DRP_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    ptr_d          = win_idx;
                    we_d           = REQ_WE_I[win_idx];
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    addr_d         = REQ_ADDR_I[32'(win_idx)*ADDR_W +: ADDR_W];
                    di_d           = REQ_DI_I[32'(win_idx)*16 +: 16];
                    drpen_d        = 1'b1;
                    drpwe_d        = REQ_WE_I[win_idx];
                end
            end
            S_WAIT: begin
                if (DRPRDY_I) begin
                    ack_d   = gnt_q;
                    rdata_d = we_q ? '0 : DRPDO_I;
                end else if (timeout) begin
                    ack_d   = gnt_q;
                    rdata_d = 16'hDEAD;
`ifdef GTP_DRP_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            S_ACK: begin
                gnt_d = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge SYSCLK_I) begin
        if (RST_I) begin
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            we_q    <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            drpen_q <= 1'b0;
            drpwe_q <= 1'b0;
            addr_q  <= '0;
            di_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            drpen_q <= drpen_d;
            drpwe_q <= drpwe_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
        end
    end

    assign ACK_O     = ack_q;
    assign RDATA_O   = rdata_q;
    assign GNT_O     = gnt_q;
    assign BUSY_O    = busy_q;
    assign DRPEN_O   = drpen_q;
    assign DRPWE_O   = drpwe_q;
    assign DRPADDR_O = addr_q;
    assign DRPDI_O   = di_q;

endmodule

// File: doc/gtp_drp_arbiter.md
Name: gtp_drp_arbiter

Overview:
- Round-robin arbiter that shares the single DRP port of one GTPE2 channel/common among several configuration requesters (IBERT-side control logic, reset sequencer, eye-scan engine).
- Accepts one read or write per grant, drives the DRP strobe protocol, and returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the requesters and the GT primitive DRP pins, in the SYSCLK_I domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 9, DRP address width.
- TIMEOUT_CYCLES, 64, WAIT-state cycles before timeout abort (used only with the optional feature).

Ports:
- SYSCLK_I  in  1  DRP/system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- REQ_I  in  NUM_REQ  per-requester request; held high until its ACK_O bit.
- REQ_WE_I  in  NUM_REQ  1 = write, 0 = read; stable while REQ_I is high.
- REQ_ADDR_I  in  ADDR_W*NUM_REQ  packed addresses; requester i uses slice i.
- REQ_DI_I  in  16*NUM_REQ  packed write data.
- ACK_O  out  NUM_REQ  one-cycle completion pulse to the owner.
- RDATA_O  out  16  read data, valid in the ACK_O cycle.
- ERR_O  out  1  high with ACK_O when the access timed out.
- GNT_O  out  NUM_REQ  one-hot current owner.
- BUSY_O  out  1  high whenever state is not IDLE.
- DRPEN_O  out  1  DRP enable strobe.
- DRPWE_O  out  1  DRP write enable.
- DRPADDR_O  out  ADDR_W  DRP address.
- DRPDI_O  out  16  DRP write data.
- DRPDO_I  in  16  DRP read data.
- DRPRDY_I  in  1  DRP ready.

Behaviour:
- Reset (RST_I sampled high):
  - All outputs go to 0 and state goes to IDLE.
  - RR pointer goes to NUM_REQ-1, so requester 0 has first priority.
  - Reset dominates all other inputs. Any in-flight DRP access is abandoned without ACK.
- FSM states: IDLE -> ACCESS -> WAIT -> ACK -> IDLE. All outputs are registered.
- IDLE:
  - If any REQ_I bit is high, pick the first set bit searching from pointer+1 upward, with modulo-NUM_REQ wrap.
  - Latch that requester's WE, ADDR and DI; set GNT_O; move pointer to the winner; go to ACCESS.
  - DRPRDY_I in IDLE is ignored.
- ACCESS (exactly 1 cycle):
  - DRPEN_O=1; DRPWE_O=latched WE; DRPADDR_O and DRPDI_O carry the latched values.
  - Go to WAIT. DRPRDY_I in this cycle is ignored.
- WAIT:
  - DRPEN_O=0, DRPWE_O=0. DRPADDR_O and DRPDI_O are held.
  - On DRPRDY_I=1: on a read, capture DRPDO_I into RDATA_O; on a write, set RDATA_O to 0. Then go to ACK.
- ACK (1 cycle):
  - ACK_O[owner]=1; ERR_O as determined above.
  - GNT_O clears on exit; go to IDLE.
- Latency: REQ_I seen in IDLE at cycle c gives DRPEN_O at c+1. DRPRDY_I at cycle d (d >= c+2) gives ACK_O at d+1. Minimum request-to-ACK is 3 cycles.
- Handshake rules:
  - A requester deasserts REQ_I in the cycle after its ACK_O.
  - If REQ_I is still high in IDLE, it is treated as a new request at lowest priority.
  - A requester that drops REQ_I before ACK is a protocol violation; the access still completes and its ACK_O still pulses.
- Simultaneous requests: exactly one grant per IDLE cycle. There are no back-to-back grants without passing through ACK.
- REQ_I changes during ACCESS, WAIT or ACK are ignored.

Optional Feature:
- Macro: GTP_DRP_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no DRPRDY_I: go to ACK with ERR_O=1 and RDATA_O=16'hDEAD.
  - DRPRDY_I and timeout in the same cycle: DRPRDY_I wins, ERR_O=0.
  - A late DRPRDY_I after the abort is ignored.
- Not defined: WAIT lasts indefinitely, ERR_O is tied to 0, and no counter is built.

Test Plan:
- Reset release, REQ_I=4'b0001 write, ADDR=9'h05E, DI=16'h1234, DRPRDY_I 2 cycles after DRPEN_O:
  - DRPEN_O=1 for one cycle, with DRPWE_O=1, DRPADDR_O=9'h05E, DRPDI_O=16'h1234.
  - ACK_O=4'b0001 one cycle after DRPRDY_I; RDATA_O=0.
- Requester 2 reads ADDR 9'h011 and the model returns DRPDO_I=16'hA5C3: ACK_O=4'b0100, RDATA_O=16'hA5C3, DRPWE_O stays 0 throughout.
- REQ_I=4'b1111 held continuously: grant order is 0,1,2,3,0; each GNT_O is one-hot and ACK_O never has two bits set.
- Assert RST_I during WAIT of a read: next cycle all outputs are 0 and state is IDLE; a subsequent stray DRPRDY_I produces no ACK; the next grant goes to requester 0.
- With GTP_DRP_TIMEOUT_EN and TIMEOUT_CYCLES=64, DRPRDY_I never asserted: ACK_O with ERR_O=1 and RDATA_O=16'hDEAD at 64 WAIT cycles after ACCESS; without the macro, BUSY_O stays high.
- DRPRDY_I asserted during the ACCESS cycle and then never again: no ACK is produced (or, with the macro, a timeout).
